// File: rtl/auc_mmulfin_if.sv
// Controller-facing bundle of the X25519 result finaliser: start/done, ALU port,
// RAM port and the outgoing byte stream.
interface auc_mmulfin_if #(
  parameter int WID   = 256,
  parameter int AWID  = 5,
  parameter int OPWID = 4
);
  logic             fin_en;
  logic             fin_done;
  logic             fin_auvld;
  logic [WID-1:0]   fin_audat;
  logic [OPWID-1:0] fin_opcode;
  logic             fin_auen;
  logic             fin_carry;
  logic             fin_swapvl;
  logic             fin_swapop;
  logic [AWID-1:0]  fin_ra;
  logic [AWID-1:0]  fin_wa;
  logic             fin_we;
  logic [WID-1:0]   fin_wd;
  logic             fin_ovld;
  logic             fin_ordy;
  logic [7:0]       fin_odat;
  logic             fin_olast;

  // master: the finaliser itself; slave: controller/ALU/RAM/byte sink side
  modport master (
    input  fin_en, fin_auvld, fin_audat, fin_ordy,
    output fin_done, fin_opcode, fin_auen, fin_carry, fin_swapvl, fin_swapop,
           fin_ra, fin_wa, fin_we, fin_wd, fin_ovld, fin_odat, fin_olast
  );
  modport slave (
    output fin_en, fin_auvld, fin_audat, fin_ordy,
    input  fin_done, fin_opcode, fin_auen, fin_carry, fin_swapvl, fin_swapop,
           fin_ra, fin_wa, fin_we, fin_wd, fin_ovld, fin_odat, fin_olast
  );
endinterface

// File: rtl/auc_mmulfin.sv
// X25519 result finaliser: reads x through the ALU, reduces mod 2^255-19 once,
// writes the little-endian encoding to RAM and streams the 32 bytes LSB first.
module auc_mmulfin #(
  parameter int WID    = 256,
  parameter int AWID   = 5,
  parameter int OPWID  = 4,
  parameter int RDADDR = 20,
  parameter int WRADDR = 15,
  parameter int IDLEWA = 30
) (
  input  logic          clk,
  input  logic          rst,
  auc_mmulfin_if.master bus
);
  localparam logic [WID-1:0]  P      = (WID'(1) << 255) - WID'(19);
  localparam logic [AWID-1:0] ZRRAM  = AWID'(18);
  localparam logic [WID-1:0]  V_MASK = {1'b0, {(WID-1){1'b1}}};

  typedef enum logic [2:0] {F_IDLE, F_RD, F_WAIT, F_WR, F_OUT} st_t;

  st_t             r_st, w_nst;
  logic [WID-1:0]  r_r;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic            r_done, r_auen, r_we, r_ovld, r_olast;
  logic [AWID-1:0] r_ra, r_wa;
  logic [WID-1:0]  r_wd;
  logic [7:0]      r_odat;

  logic            w_done, w_auen, w_we, w_ovld, w_olast, w_xfer, w_cap;
  logic [AWID-1:0] w_ra, w_wa;
  logic [WID-1:0]  w_wd, w_v, w_r, w_enc;
  logic [WID:0]    w_d;
  logic [7:0]      w_odat;

  // Input is < 2^255 once bit 255 is dropped, so a single conditional subtract suffices
  assign w_v   = bus.fin_audat & V_MASK;
  assign w_d   = {1'b0, w_v} - {1'b0, P};
  assign w_r   = w_d[WID] ? w_v : w_d[WID-1:0];
  assign w_cap = (r_st == F_WAIT) && bus.fin_auvld;

  always_comb begin
    w_enc = '0;
    for (int k = 0; k < WID/8; k++) w_enc[8*(WID/8-1-k) +: 8] = r_r[8*k +: 8];
  end

  assign w_xfer = (r_st == F_OUT) && r_ovld && bus.fin_ordy;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_st <= F_IDLE;
    else     r_st <= w_nst;
  end

  // next-state logic
  always_comb begin
    w_nst = r_st;
    unique case (r_st)
      F_IDLE: if (bus.fin_en) w_nst = F_RD;
      F_RD:   w_nst = F_WAIT;
      F_WAIT: if (bus.fin_auvld) w_nst = F_WR;
      F_WR:   w_nst = F_OUT;
      F_OUT:  if (w_xfer && r_cnt == 5'd31) w_nst = F_IDLE;
      default: w_nst = F_IDLE;
    endcase
  end

  // output logic; stream outputs look at the next state so the byte is up with F_OUT
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_st == F_WR)  w_cnt_nxt = 5'd0;
    else if (w_xfer)   w_cnt_nxt = r_cnt + 5'd1;
    w_ra    = (r_st == F_RD) ? AWID'(RDADDR) : ZRRAM;
    w_auen  = (r_st == F_RD);
    w_we    = (r_st == F_WR);
    w_wa    = w_we ? AWID'(WRADDR) : AWID'(IDLEWA);
    w_wd    = w_we ? w_enc : '0;
    w_ovld  = (w_nst == F_OUT);
    w_odat  = w_ovld ? r_r[{w_cnt_nxt, 3'b000} +: 8] : 8'd0;
    w_olast = w_ovld && (w_cnt_nxt == 5'd31);
    w_done  = w_xfer && (r_cnt == 5'd31);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= '0;
      r_cnt   <= '0;
      r_ra    <= ZRRAM;
      r_auen  <= 1'b0;
      r_we    <= 1'b0;
      r_wa    <= AWID'(IDLEWA);
      r_wd    <= '0;
      r_ovld  <= 1'b0;
      r_odat  <= '0;
      r_olast <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_cap) r_r <= w_r;
      r_cnt   <= w_cnt_nxt;
      r_ra    <= w_ra;
      r_auen  <= w_auen;
      r_we    <= w_we;
      r_wa    <= w_wa;
      r_wd    <= w_wd;
      r_ovld  <= w_ovld;
      r_odat  <= w_odat;
      r_olast <= w_olast;
      r_done  <= w_done;
    end
  end

  assign bus.fin_done   = r_done;
  assign bus.fin_auen   = r_auen;
  assign bus.fin_ra     = r_ra;
  assign bus.fin_we     = r_we;
  assign bus.fin_wa     = r_wa;
  assign bus.fin_wd     = r_wd;
  assign bus.fin_ovld   = r_ovld;
  assign bus.fin_odat   = r_odat;
  assign bus.fin_olast  = r_olast;
  assign bus.fin_opcode = OPWID'(4'b0100);
  assign bus.fin_carry  = 1'b0;
  assign bus.fin_swapvl = 1'b1;
  assign bus.fin_swapop = 1'b1;
endmodule

// File: tb/tb_auc_mmulfin.sv
// Directed bench for auc_mmulfin: reduction corner cases, encoding, stream
// back-pressure, mid-stream reset and ignored fin_en.
module tb_auc_mmulfin;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  auc_mmulfin_if #(.WID(256), .AWID(5), .OPWID(4)) ifc ();
  auc_mmulfin dut (.clk(clk), .rst(rst), .bus(ifc.master));

  int ncmp = 0, nerr = 0;
  int n_auen, n_we, n_done;
  logic [255:0] last_wd;
  logic [4:0]   last_wa;
  logic [7:0]   got[$];
  logic         lastq[$];
  logic         hold_prev = 1'b0;
  logic [7:0]   odat_prev;

  localparam logic [255:0] V_P   = {4'h7, {61{4'hf}}, 8'hed};
  localparam logic [255:0] V_P1  = {4'h7, {61{4'hf}}, 8'hee};
  localparam logic [255:0] V_PM1 = {4'h7, {61{4'hf}}, 8'hec};
  localparam logic [255:0] V_B5  = {1'b1, 255'd5};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Event recorder: samples mid-cycle, when the values the next edge will see are settled
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.fin_auen) n_auen++;
      if (ifc.fin_we) begin n_we++; last_wd = ifc.fin_wd; last_wa = ifc.fin_wa; end
      if (ifc.fin_done) n_done++;
      if (hold_prev) begin
        chk("ovld_hold", ifc.fin_ovld, 1'b1);
        chk("odat_hold", ifc.fin_odat, odat_prev);
      end
      if (ifc.fin_ovld && ifc.fin_ordy) begin got.push_back(ifc.fin_odat); lastq.push_back(ifc.fin_olast); end
      hold_prev = ifc.fin_ovld && !ifc.fin_ordy;
      odat_prev = ifc.fin_odat;
    end else hold_prev = 1'b0;
  end

  task automatic clr();
    n_auen = 0; n_we = 0; n_done = 0; got.delete(); lastq.delete();
  endtask

  // mode 0: ordy high; mode 1: ordy 1,0,0 pattern; mode 2: extra fin_en during F_WAIT
  task automatic run(input string nm, input logic [255:0] vin, input logic [255:0] ex, input int mode);
    logic [255:0] ewd;
    int i;
    for (int k = 0; k < 32; k++) ewd[8*(31-k) +: 8] = ex[8*k +: 8];
    clr();
    ifc.fin_en = 1'b1; cyc(); ifc.fin_en = 1'b0;
    chk({nm, ":auen_t1"}, ifc.fin_auen, 1'b0);
    cyc();
    chk({nm, ":auen_t2"}, ifc.fin_auen, 1'b1);
    chk({nm, ":ra_rd"}, ifc.fin_ra, 5'd20);
    cyc();
    chk({nm, ":auen_pulse"}, ifc.fin_auen, 1'b0);
    chk({nm, ":ra_idle"}, ifc.fin_ra, 5'd18);
    cyc();
    if (mode == 2) begin ifc.fin_en = 1'b1; cyc(); ifc.fin_en = 1'b0; end
    cyc();
    ifc.fin_auvld = 1'b1; ifc.fin_audat = vin; cyc();
    ifc.fin_auvld = 1'b0; ifc.fin_audat = '0;
    chk({nm, ":we_a1"}, ifc.fin_we, 1'b0);
    cyc();
    chk({nm, ":we_a2"}, ifc.fin_we, 1'b1);
    chk({nm, ":wa"}, ifc.fin_wa, 5'd15);
    chk({nm, ":wd"}, ifc.fin_wd, ewd);
    chk({nm, ":ovld_a2"}, ifc.fin_ovld, 1'b1);
    chk({nm, ":odat0"}, ifc.fin_odat, ex[7:0]);
    i = 0;
    while (n_done == 0 && i < 300) begin
      ifc.fin_ordy = (mode == 1) ? ((i % 3) == 0) : 1'b1;
      cyc(); i++;
    end
    ifc.fin_ordy = 1'b0;
    chk({nm, ":done_seen"}, n_done, 1);
    if (mode == 0) chk({nm, ":done_lat"}, i, 33);
    repeat (3) cyc();
    chk({nm, ":n_done"}, n_done, 1);
    chk({nm, ":n_we"}, n_we, 1);
    chk({nm, ":n_auen"}, n_auen, 1);
    chk({nm, ":nbytes"}, got.size(), 32);
    chk({nm, ":wa_idle"}, ifc.fin_wa, 5'd30);
    chk({nm, ":ovld_end"}, ifc.fin_ovld, 1'b0);
    for (int k = 0; k < 32; k++)
      if (k < got.size()) begin
        chk($sformatf("%s:byte%0d", nm, k), got[k], ex[8*k +: 8]);
        chk($sformatf("%s:last%0d", nm, k), lastq[k], k == 31);
      end
  endtask

  initial begin
    int i;
    ifc.fin_en = 1'b0; ifc.fin_auvld = 1'b0; ifc.fin_audat = '0; ifc.fin_ordy = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst:ra", ifc.fin_ra, 5'd18);
    chk("rst:wa", ifc.fin_wa, 5'd30);
    chk("rst:we", ifc.fin_we, 1'b0);
    chk("rst:wd", ifc.fin_wd, 256'd0);
    chk("rst:auen", ifc.fin_auen, 1'b0);
    chk("rst:ovld", ifc.fin_ovld, 1'b0);
    chk("rst:odat", ifc.fin_odat, 8'd0);
    chk("rst:olast", ifc.fin_olast, 1'b0);
    chk("rst:done", ifc.fin_done, 1'b0);
    chk("const:opcode", ifc.fin_opcode, 4'b0100);
    chk("const:carry", ifc.fin_carry, 1'b0);
    chk("const:swap", {ifc.fin_swapvl, ifc.fin_swapop}, 2'b11);

    run("v9", 256'd9, 256'd9, 0);
    run("vp", V_P, 256'd0, 0);
    run("vp1", V_P1, 256'd1, 1);
    run("vpm1", V_PM1, V_PM1, 0);
    run("b255", V_B5, 256'd5, 0);

    // mid-stream reset at byte 10
    clr();
    ifc.fin_en = 1'b1; cyc(); ifc.fin_en = 1'b0;
    repeat (4) cyc();
    ifc.fin_auvld = 1'b1; ifc.fin_audat = 256'h0123_4567_89ab_cdef; cyc();
    ifc.fin_auvld = 1'b0; ifc.fin_audat = '0;
    ifc.fin_ordy = 1'b1;
    i = 0;
    while (got.size() < 10 && i < 100) begin cyc(); i++; end
    chk("rstmid:reach10", got.size() >= 10, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rstmid:ovld", ifc.fin_ovld, 1'b0);
    chk("rstmid:we", ifc.fin_we, 1'b0);
    chk("rstmid:done", ifc.fin_done, 1'b0);
    repeat (5) cyc();
    chk("rstmid:n_done", n_done, 0);
    chk("rstmid:ovld_later", ifc.fin_ovld, 1'b0);
    ifc.fin_ordy = 1'b0;

    run("enwait", 256'h00a5_5a00_1234, 256'h00a5_5a00_1234, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
